// File: rtl/instr_seq_ctrl_if.sv
// Sequencer bus: start, memory handshakes,
// decoder inputs and control strobes.
interface instr_seq_ctrl_if #(
  parameter int PC_W = 8
);
  logic            start;
  logic            imem_ready;
  logic            dmem_ready;
  logic [4:0]      aluopcode;
  logic            regen;
  logic [PC_W-1:0] pc;
  logic            imem_req;
  logic            ir_load;
  logic            decode_en;
  logic            alu_en;
  logic            dmem_req;
  logic            dmem_we;
  logic            reg_we;
  logic            busy;
  logic            halted;
  logic            error;
  logic [7:0]      retired;
  logic [2:0]      state;

  modport master (
    input  start, imem_ready, dmem_ready,
    input  aluopcode, regen,
    output pc, imem_req, ir_load, decode_en,
    output alu_en, dmem_req, dmem_we, reg_we,
    output busy, halted, error, retired, state
  );

  modport slave (
    output start, imem_ready, dmem_ready,
    output aluopcode, regen,
    input  pc, imem_req, ir_load, decode_en,
    input  alu_en, dmem_req, dmem_we, reg_we,
    input  busy, halted, error, retired, state
  );
endinterface

// File: rtl/instr_seq_ctrl.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer
// with PC, retire counter and memory timeout.
module instr_seq_ctrl #(
  parameter int              PC_W        = 8,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int              MEM_TIMEOUT = 15
) (
  input logic              clock,
  input logic              reset_n,
  instr_seq_ctrl_if.master bus
);

  localparam int WC_W =
    (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] TMO =
    WC_W'(MEM_TIMEOUT);

  localparam logic [4:0] OP_HALT  = 5'b11111;
  localparam logic [4:0] OP_LOAD  = 5'b11110;
  localparam logic [4:0] OP_STORE = 5'b11101;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  state_t          cur;
  state_t          nxt;
  logic [PC_W-1:0] pc_q;
  logic [7:0]      ret_q;
  logic [WC_W-1:0] wcnt;
  logic            st_q;
  logic            wc_inc;
  logic            adv;
  logic            is_halt;
  logic            is_ld;
  logic            is_st;

  assign is_halt = bus.aluopcode == OP_HALT;
  assign is_ld   = bus.aluopcode == OP_LOAD;
  assign is_st   = bus.aluopcode == OP_STORE;

  // Next state, wait-counter step and retire strobe
  always_comb begin
    nxt    = cur;
    wc_inc = 1'b0;
    adv    = 1'b0;
    unique case (cur)
      S_IDLE: begin
        if (bus.start) nxt = S_FETCH;
      end
      S_FETCH: begin
        if (bus.imem_ready) nxt = S_DECODE;
        else if (wcnt == TMO) nxt = S_ERROR;
        else wc_inc = 1'b1;
      end
      S_DECODE: nxt = S_EXEC;
      S_EXEC: begin
        unique case (1'b1)
          is_halt:      nxt = S_HALT;
          is_ld, is_st: nxt = S_MEM;
          default:      nxt = S_WB;
        endcase
      end
      S_MEM: begin
        if (bus.dmem_ready) begin
          nxt = st_q ? S_FETCH : S_WB;
          adv = st_q;
        end else if (wcnt == TMO) begin
          nxt = S_ERROR;
        end else begin
          wc_inc = 1'b1;
        end
      end
      S_WB: begin
        nxt = S_FETCH;
        adv = 1'b1;
      end
      S_HALT:  nxt = S_HALT;
      S_ERROR: nxt = S_ERROR;
      default: nxt = S_IDLE;
    endcase
  end

  // State, PC, retire count and wait counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur   <= S_IDLE;
      pc_q  <= RESET_PC;
      ret_q <= '0;
      wcnt  <= '0;
      st_q  <= 1'b0;
    end else begin
      cur <= nxt;
      if (nxt != cur) wcnt <= '0;
      else if (wc_inc) wcnt <= wcnt + WC_W'(1);
      if (cur == S_EXEC) st_q <= is_st;
      if (adv) begin
        pc_q <= pc_q + PC_W'(1);
        if (ret_q != 8'hFF) ret_q <= ret_q + 8'd1;
      end
    end
  end

  // Moore strobes decoded from state; ir_load follows imem_ready
  always_comb begin
    bus.imem_req  = cur == S_FETCH;
    bus.ir_load   = (cur == S_FETCH) && bus.imem_ready;
    bus.decode_en = cur == S_DECODE;
    bus.alu_en    = cur == S_EXEC;
    bus.dmem_req  = cur == S_MEM;
    bus.dmem_we   = (cur == S_MEM) && st_q;
    bus.reg_we    = (cur == S_WB) && bus.regen;
    bus.busy      = (cur != S_IDLE) && (cur != S_HALT)
                    && (cur != S_ERROR);
    bus.halted    = cur == S_HALT;
    bus.error     = cur == S_ERROR;
    bus.retired   = ret_q;
    bus.state     = cur;
    bus.pc        = pc_q;
  end

endmodule
